cic_sample_uart_tx: RTL and testbench



---
 rtl/cic_uart_pkg.sv | 14 +
 rtl/uart_tx_8n1.sv | 89 ++++++++
 rtl/cic_sample_uart_tx.sv | 89 ++++++++
 tb/tb_cic_sample_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_uart_pkg.sv
// Shared types and framing constants for the CIC sample UART path.
package cic_uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a registered serial output; accepts a byte on load while ready.
module uart_tx_8n1
  import cic_uart_pkg::*;
#(
  parameter int BAUD_DIV = 1,
  parameter int BAUD_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 ready
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] sr;
  logic                 baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != ST_IDLE);
  assign ready    = (state == ST_IDLE);

  // tx is loaded with the level of the bit being entered, so it changes on the
  // same edge as the state and never needs a combinational output decode.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sr       <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (load) begin
            sr       <= data;
            baud_cnt <= '0;
            state    <= ST_START;
            tx       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            tx       <= sr[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            sr       <= sr >> 1;
            if (bit_idx == BIT_LAST) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= sr[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cic_sample_uart_tx.sv
// Captures decimated CIC samples on each downsample-clock rise into a FIFO and
// drains them over 8N1 UART; bit7 of a byte marks that samples were lost before it.
module cic_sample_uart_tx
  import cic_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 1,
  parameter int BAUD_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_clk_i,
  input  logic [6:0]                    sample_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  logic                 sclk_q;
  logic                 drop_pend;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic                 rise;
  logic                 ready;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign rise = sample_clk_i & ~sclk_q;
  assign pop  = ready & (level_o != '0);
  // A full FIFO still takes the sample when the transmitter frees a slot this cycle.
  assign push = rise & ((level_o < FULL_LEVEL) | pop);
  assign drop = rise & ~push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q     <= 1'b0;
      drop_pend  <= 1'b0;
      overflow_o <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
    end else begin
      sclk_q <= sample_clk_i;
      if (push)
        drop_pend <= 1'b0;
      else if (drop)
        drop_pend <= 1'b1;
      if (drop)
        overflow_o <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: level_o <= level_o;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which entries are valid, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {drop_pend, sample_i};
  end

  uart_tx_8n1 #(
    .BAUD_DIV (BAUD_DIV),
    .BAUD_W   (BAUD_W)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pop),
    .data  (mem[rd_ptr]),
    .tx    (tx_o),
    .busy  (busy_o),
    .ready (ready)
  );

endmodule

// File: tb/tb_cic_sample_uart_tx.sv
// Directed bench: a fast-baud and a slow-baud instance, a UART receive monitor and hand-computed byte streams.
module tb_cic_sample_uart_tx;
  import cic_uart_pkg::*;

  typedef struct {
    logic [6:0] sample;
    logic [7:0] exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_f, rst_s;
  logic       sclk_f, sclk_s;
  logic [6:0] samp_f, samp_s;
  logic       tx_f, busy_f, ovf_f;
  logic       tx_s, busy_s, ovf_s;
  logic [2:0] lvl_f, lvl_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cic_sample_uart_tx #(.FIFO_DEPTH(4), .BAUD_DIV(1), .BAUD_W(8)) u_fast (
    .clk(clk), .rst_n(rst_f), .sample_clk_i(sclk_f), .sample_i(samp_f),
    .tx_o(tx_f), .busy_o(busy_f), .overflow_o(ovf_f), .level_o(lvl_f)
  );

  cic_sample_uart_tx #(.FIFO_DEPTH(4), .BAUD_DIV(4), .BAUD_W(8)) u_slow (
    .clk(clk), .rst_n(rst_s), .sample_clk_i(sclk_s), .sample_i(samp_s),
    .tx_o(tx_s), .busy_o(busy_s), .overflow_o(ovf_s), .level_o(lvl_s)
  );

  // UART receive monitor on the selected instance, sampling each bit at its first cycle.
  logic       mon_sel = 1'b0;
  logic       tx_mon;
  int         mon_bd;
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_k;
  logic [7:0] mon_sr = '0;
  logic       rst_seen = 1'b0;
  int         frame_err = 0;
  logic [7:0] rx_q[$];

  assign tx_mon = mon_sel ? tx_s : tx_f;
  assign mon_bd = mon_sel ? 4 : 1;

  always @(posedge clk) rst_seen <= !(rst_f && rst_s);

  always @(negedge clk) begin
    if (rst_seen) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx_mon == 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 1;
      end
    end else begin
      if (mon_cnt % mon_bd == 0) begin
        mon_k = mon_cnt / mon_bd;
        if (mon_k <= DATA_BITS) begin
          mon_sr[mon_k-1] = tx_mon;
        end else begin
          if (tx_mon !== 1'b1) frame_err++;
          rx_q.push_back(mon_sr);
          mon_act = 1'b0;
        end
      end
      mon_cnt++;
    end
  end

  logic       track = 1'b0;
  logic [2:0] max_lvl = '0;
  always @(negedge clk) if (track && lvl_f > max_lvl) max_lvl = lvl_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic pulse_f(input logic [6:0] s);
    sclk_f = 1'b1;
    samp_f = s;
    @(negedge clk);
    sclk_f = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_s(input logic [6:0] s);
    sclk_s = 1'b1;
    samp_s = s;
    @(negedge clk);
    sclk_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp);
    logic [7:0] b;
    if (rx_q.size() == 0) begin
      check(name, 32'hdead, {24'h0, exp});
    end else begin
      b = rx_q.pop_front();
      check(name, b, exp);
    end
  endtask

  vec_t       vecs[6];
  logic [7:0] exp_seq[7];
  logic       exp_tx[12];
  logic       exp_busy[12];
  int         c;
  int         busy_cnt;
  int         tx_low;

  initial begin
    vecs[0] = '{sample: 7'h55, exp_byte: 8'h55};
    vecs[1] = '{sample: 7'h00, exp_byte: 8'h00};
    vecs[2] = '{sample: 7'h7f, exp_byte: 8'h7f};
    vecs[3] = '{sample: 7'h2a, exp_byte: 8'h2a};
    vecs[4] = '{sample: 7'h01, exp_byte: 8'h01};
    vecs[5] = '{sample: 7'h40, exp_byte: 8'h40};

    // 0x55 framed LSB first, sampled from the cycle after the push edge.
    exp_tx   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_f = 1'b0; rst_s = 1'b0;
    sclk_f = 1'b0; sclk_s = 1'b0;
    samp_f = '0; samp_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1; rst_s = 1'b1;

    // Reset state and an idle line for 50 cycles.
    check("rst_slow_tx", tx_s, 1);
    check("rst_slow_busy", busy_s, 0);
    check("rst_slow_lvl", lvl_s, 0);
    check("rst_slow_ovf", ovf_s, 0);
    for (int i = 0; i < 50; i++) begin
      check("idle_tx", tx_f, 1);
      check("idle_busy", busy_f, 0);
      check("idle_lvl", lvl_f, 0);
      @(negedge clk);
    end
    check("idle_ovf", ovf_f, 0);

    // Exact frame timing for one 0x55 sample.
    sclk_f = 1'b1;
    samp_f = 7'h55;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) sclk_f = 1'b0;
      check("t2_tx", tx_f, exp_tx[i]);
      check("t2_busy", busy_f, exp_busy[i]);
      if (i == 0) check("t2_lvl_pushed", lvl_f, 1);
      if (i == 1) check("t2_lvl_popped", lvl_f, 0);
      if (busy_f) busy_cnt++;
    end
    check("t2_busy_cycles", busy_cnt, FRAME_BITS);
    wait_rx(1, 5);
    check_rx("t2_byte", 8'h55);

    // Table of single-sample frames.
    for (int v = 0; v < 6; v++) begin
      pulse_f(vecs[v].sample);
      wait_rx(1, 30);
      check_rx("vec_byte", vecs[v].exp_byte);
      @(negedge clk);
      check("vec_busy_done", busy_f, 0);
      check("vec_lvl_done", lvl_f, 0);
    end

    // CIC-rate source: one rise every 12 cycles, 100 samples.
    max_lvl = '0;
    track = 1'b1;
    for (int p = 0; p < 100; p++) begin
      sclk_f = 1'b1;
      samp_f = 7'(p);
      repeat (6) @(negedge clk);
      sclk_f = 1'b0;
      repeat (6) @(negedge clk);
    end
    wait_rx(100, 40);
    track = 1'b0;
    for (int p = 0; p < 100; p++) check_rx("t3_byte", {1'b0, 7'(p)});
    check("t3_ovf", ovf_f, 0);
    check("t3_max_lvl", max_lvl, 1);

    // Fast source into the slow-baud instance: 5 delivered, 5 dropped.
    mon_sel = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 10; i++) pulse_s(7'h10 + 7'(i));
    check("t4_lvl_full", lvl_s, 4);
    check("t4_ovf", ovf_s, 1);
    c = 0;
    while (lvl_s !== 3'd3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t4_lvl_drain", lvl_s, 3);
    pulse_s(7'h2a);
    check("t4_lvl_refill", lvl_s, 4);
    wait_rx(6, 400);
    pulse_s(7'h33);
    wait_rx(7, 80);
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'haa, 8'h33};
    for (int i = 0; i < 7; i++) check_rx("t4_byte", exp_seq[i]);
    check("t4_ovf_sticky", ovf_s, 1);

    // Push on the very cycle a full FIFO is popped.
    rst_s = 1'b0;
    @(negedge clk);
    rst_s = 1'b1;
    check("t5_rst_ovf", ovf_s, 0);
    @(negedge clk);
    rx_q.delete();
    for (int i = 0; i < 5; i++) pulse_s(7'h41 + 7'(i));
    check("t5_lvl_full", lvl_s, 4);
    check("t5_busy", busy_s, 1);
    c = 0;
    while (busy_s !== 1'b0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t5_idle_reached", busy_s, 0);
    check("t5_lvl_before", lvl_s, 4);
    sclk_s = 1'b1;
    samp_s = 7'h46;
    @(negedge clk);
    sclk_s = 1'b0;
    check("t5_lvl_after", lvl_s, 4);
    check("t5_ovf", ovf_s, 0);
    wait_rx(6, 400);
    for (int i = 0; i < 6; i++) check_rx("t5_byte", 8'h41 + 8'(i));

    // Reset mid-frame on the fast instance.
    mon_sel = 1'b0;
    @(negedge clk);
    rx_q.delete();
    for (int i = 0; i < 8; i++) pulse_f(7'h50 + 7'(i));
    check("t6_pre_busy", busy_f, 1);
    check("t6_pre_ovf", ovf_f, 1);
    check("t6_pre_lvl", lvl_f, 4);
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    check("t6_tx", tx_f, 1);
    check("t6_busy", busy_f, 0);
    check("t6_lvl", lvl_f, 0);
    check("t6_ovf", ovf_f, 0);
    tx_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_f !== 1'b1) tx_low++;
    end
    check("t6_no_glitch", tx_low, 0);
    rx_q.delete();
    pulse_f(7'h3c);
    wait_rx(1, 30);
    check_rx("t6_clean_byte", 8'h3c);

    check("frame_errors", frame_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
